// File: rtl/coef_rom_reader.sv
// Burst sequencer: reads count coefficient words from a 1-cycle-latency ROM
// starting at base (wrapping modulo DEPTH) and streams them on valid/ready.
module coef_rom_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 20,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_cen,
  input  logic [DATA_W-1:0] rom_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  out_idx;
  logic              pend;
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;

  // A read may issue only if the FIFO still has room once the word already
  // in flight lands, counting a slot freed by this cycle's pop.
  always_comb begin
    pop   = m_valid & m_ready;
    occ   = 3'(fifo_cnt) + 3'(pend) - 3'(pop);
    issue = (state == RUN) && (issued < count_r) && (occ < 3'd2);
  end

  assign rom_cen = issue;
  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid && (out_idx == count_r - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_a    <= '0;
      count_r  <= '0;
      issued   <= '0;
      out_idx  <= '0;
      pend     <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
      // NOTE: the two skid entries are reset because m_data must read 0
      // after reset; a large RAM would normally be left unreset.
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      pend <= issue;
      if (issue) begin
        rom_a  <= (rom_a == ADDR_W'(DEPTH - 1)) ? '0 : rom_a + ADDR_W'(1);
        issued <= issued + CNT_W'(1);
      end
      // rom_q is only meaningful the cycle after an issued read.
      if (pend) begin
        mem[wr_ptr] <= rom_q;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_idx <= out_idx + CNT_W'(1);
      end
      fifo_cnt <= fifo_cnt + 2'(pend) - 2'(pop);

      case (state)
        IDLE: begin
          if (start) begin
            count_r <= count;
            rom_a   <= base;
            issued  <= '0;
            out_idx <= '0;
            busy    <= 1'b1;
            if (count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (pop && m_last) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_rom_reader.sv
// Directed bench for coef_rom_reader: ROM model returns 16'h1000+addr, a
// negedge monitor logs reads/handshakes, expectations are hand-computed.
module tb_coef_rom_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic [7:0]  rom_a;
  logic        rom_cen;
  logic [15:0] rom_q;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;

  int checks = 0;
  int errors = 0;
  int cyc;

  int          cen_cyc[$];
  logic [7:0]  cen_addr[$];
  int          out_cyc[$];
  logic [15:0] out_data[$];
  logic        out_last[$];
  int          done_n;
  int          done_cyc;
  int          busy_n;
  int          hold_err;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic [15:0] data_c5;

  always #5 clk = ~clk;

  coef_rom_reader dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .rom_a(rom_a), .rom_cen(rom_cen),
    .rom_q(rom_q), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
  );

  // Synchronous ROM: Q holds stale data when not enabled.
  always @(posedge clk) if (rom_cen) rom_q <= 16'h1000 + 16'(rom_a);

  always @(negedge clk) begin
    if (!reset) begin
      if (rom_cen) begin
        cen_cyc.push_back(cyc);
        cen_addr.push_back(rom_a);
      end
      if (m_valid && m_ready) begin
        out_cyc.push_back(cyc);
        out_data.push_back(m_data);
        out_last.push_back(m_last);
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (busy) busy_n++;
      if (prev_stall && (!m_valid || m_data != prev_data)) hold_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (cyc == 5) data_c5 = m_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    cen_cyc.delete(); cen_addr.delete();
    out_cyc.delete(); out_data.delete(); out_last.delete();
    done_n = 0; done_cyc = -1; busy_n = 0; hold_err = 0;
    prev_stall = 1'b0; prev_data = '0; data_c5 = '0;
  endtask

  // Start a burst in cycle 0, stall m_ready over [s0,s1], optionally pulse
  // a second start (count xc) in cycle xs, then run a fixed cycle budget.
  task automatic run_burst(input logic [7:0] b, input logic [7:0] c,
                           input int s0, input int s1,
                           input int xs, input logic [7:0] xc);
    clear_log();
    cyc     = 0;
    start   = 1'b1;
    base    = b;
    count   = c;
    m_ready = !(0 >= s0 && 0 <= s1);
    for (int k = 1; k <= int'(c) + 20; k++) begin
      step();
      start   = (cyc == xs);
      count   = (cyc == xs) ? xc : c;
      m_ready = !(cyc >= s0 && cyc <= s1);
    end
    start   = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic check_words(input string tag, input logic [7:0] b, input int n);
    check({tag, "_nwords"}, out_data.size(), n);
    for (int i = 0; i < n && i < out_data.size(); i++) begin
      check({tag, "_data"}, out_data[i], 16'h1000 + 16'((int'(b) + i) % 20));
      check({tag, "_last"}, out_last[i], (i == n - 1));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base = '0; count = '0; m_ready = 1'b1;
    cyc = 0;
    clear_log();
    repeat (3) step();
    check("rst_busy",  busy,    0);
    check("rst_done",  done,    0);
    check("rst_cen",   rom_cen, 0);
    check("rst_addr",  rom_a,   0);
    check("rst_valid", m_valid, 0);
    check("rst_data",  m_data,  0);
    check("rst_last",  m_last,  0);
    reset = 1'b0;
    step();

    // Basic burst with exact cycle timing.
    run_burst(8'd0, 8'd4, 1000, 1000, -1, 8'd0);
    check("b1_ncen", cen_cyc.size(), 4);
    for (int i = 0; i < 4 && i < cen_cyc.size(); i++) begin
      check("b1_cen_cyc",  cen_cyc[i],  i + 1);
      check("b1_cen_addr", cen_addr[i], i);
    end
    check_words("b1", 8'd0, 4);
    for (int i = 0; i < 4 && i < out_cyc.size(); i++) check("b1_out_cyc", out_cyc[i], i + 3);
    check("b1_done_n",   done_n,   1);
    check("b1_done_cyc", done_cyc, 7);
    check("b1_busy_n",   busy_n,   7);
    check("b1_idle",     busy,     0);

    // Address wrap from DEPTH-1 back to 0.
    run_burst(8'd18, 8'd4, 1000, 1000, -1, 8'd0);
    check("wrap_ncen", cen_addr.size(), 4);
    for (int i = 0; i < 4 && i < cen_addr.size(); i++)
      check("wrap_addr", cen_addr[i], (18 + i) % 20);
    check_words("wrap", 8'd18, 4);

    // Backpressure over cycles 3-7.
    run_burst(8'd0, 8'd5, 3, 7, -1, 8'd0);
    check("stall_c5_data", data_c5, 16'h1000);
    check("stall_hold", hold_err, 0);
    begin
      int n = 0;
      foreach (cen_cyc[i]) if (cen_cyc[i] >= 3 && cen_cyc[i] <= 7) n++;
      check("stall_no_cen", n, 0);
    end
    check("stall_ncen", cen_cyc.size(), 5);
    check_words("stall", 8'd0, 5);
    check("stall_done_n", done_n, 1);

    // Empty burst.
    run_burst(8'd3, 8'd0, 1000, 1000, -1, 8'd0);
    check("zero_ncen",     cen_cyc.size(),  0);
    check("zero_nwords",   out_data.size(), 0);
    check("zero_done_n",   done_n,   1);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_busy_n",   busy_n,   1);

    // Start while busy is ignored.
    run_burst(8'd0, 8'd3, 1000, 1000, 2, 8'd9);
    check_words("busy_start", 8'd0, 3);
    check("busy_start_done_n", done_n, 1);

    // Start on the done cycle (cycle 6) is ignored.
    run_burst(8'd0, 8'd3, 1000, 1000, 6, 8'd2);
    check("done_start_cyc",   done_cyc,        6);
    check("done_start_words", out_data.size(), 3);
    check("done_start_done",  done_n,          1);

    // Start one cycle after done is accepted.
    run_burst(8'd0, 8'd3, 1000, 1000, 7, 8'd2);
    check("after_done_words", out_data.size(), 5);
    check("after_done_done",  done_n,          2);
    if (out_data.size() == 5) begin
      check("after_done_d3",   out_data[3], 16'h1000);
      check("after_done_last", out_last[4], 1);
    end

    // Reset mid-burst after two words.
    clear_log();
    cyc = 0; start = 1'b1; base = 8'd5; count = 8'd6; m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      start = 1'b0;
    end
    step();
    reset = 1'b1;
    step();
    check("mid_rst_words", out_data.size(), 2);
    check("mid_rst_busy",  busy,    0);
    check("mid_rst_done",  done,    0);
    check("mid_rst_cen",   rom_cen, 0);
    check("mid_rst_addr",  rom_a,   0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data",  m_data,  0);
    check("mid_rst_last",  m_last,  0);
    check("mid_rst_done_n", done_n, 0);
    reset = 1'b0;
    step();
    run_burst(8'd5, 8'd3, 1000, 1000, -1, 8'd0);
    check_words("post_rst", 8'd5, 3);
    check("post_rst_done_n", done_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coef_rom_reader.md
Name: coef_rom_reader

Overview:
Sequencer that reads a burst of coefficient words out of a synchronous-read coefficient ROM and streams them on a valid/ready output. It drives the ROM's address and chip-enable and absorbs the ROM's 1-cycle read latency. A 2-entry skid buffer gives full throughput with no loss under backpressure. It sits between the coefficient ROM and the consuming datapath (MAC/filter engine).

Parameters:
ADDR_W, 8, ROM address width
DATA_W, 16, ROM/stream data width
DEPTH, 20, number of valid ROM entries; addresses wrap modulo DEPTH
CNT_W, 8, width of burst length input

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  pulse; begin burst (sampled only when idle)
base  input  ADDR_W  first ROM address of burst (must be < DEPTH)
count  input  CNT_W  number of words in burst
busy  output  1  burst in progress
done  output  1  1-cycle pulse at burst end
rom_a  output  ADDR_W  ROM address
rom_cen  output  1  ROM read enable
rom_q  input  DATA_W  ROM data, valid the cycle after rom_cen
m_valid  output  1  stream data valid
m_ready  input  1  consumer ready
m_data  output  DATA_W  stream data
m_last  output  1  marks final word of burst

Behaviour:
- Reset: state=IDLE. busy=0, done=0, rom_cen=0, rom_a=0, m_valid=0, m_data=0, m_last=0. FIFO, pending flag and counters are cleared. Reset mid-burst aborts the burst: no done pulse, and a ROM read in flight is discarded.
- States: IDLE, RUN, FIN.
- IDLE: start=1 latches base and count. count!=0 goes to RUN and sets busy=1 on the next cycle. count==0 goes to FIN (busy=1 for one cycle, no ROM reads).
- start is ignored while busy=1.
- Read issue in RUN: rom_cen=1 when issued<count and (fifo_cnt + pend - pop) < 2, where pend is the read issued last cycle and pop = m_valid & m_ready this cycle.
- rom_a = current read address. It advances by 1 per issued read and wraps from DEPTH-1 to 0. rom_a holds its value when rom_cen=0.
- Capture: pend=1 pushes rom_q into the 2-entry FIFO at the end of that cycle. rom_q is never captured in any other cycle, because the ROM holds stale Q when rom_cen=0.
- Output: m_valid = FIFO non-empty. m_data = FIFO head. m_last=1 when the head is word number count-1.
- Data, last and valid hold stable while m_valid & !m_ready. The FIFO never overflows.
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- Latency: start in cycle 0 gives rom_cen=1 in cycle 1 and m_valid=1 in cycle 3. With m_ready held at 1, output is 1 word/cycle after that.
- End of burst: handshake of the m_last word goes to FIN. In FIN: done=1 for one cycle, then IDLE with busy=0 from the following cycle.
- A start in the same cycle as done is ignored. A new start is accepted from the first IDLE cycle.
- Counters are CNT_W bits wide; count up to 2^CNT_W-1 is supported. Addresses keep wrapping modulo DEPTH.

Test Plan:
- ROM model returns 16'h1000+addr. start, base=0, count=4, m_ready=1 -> rom_cen in cycles 1-4 at addresses 0,1,2,3; m_data 1000,1001,1002,1003 in cycles 3-6; m_last in cycle 6; done in cycle 7.
- base=18, count=4 -> addresses 18,19,0,1; data 1012,1013,1000,1001.
- count=5, m_ready low for cycles 3-7 -> m_data stays 1000 and valid through the stall; rom_cen=0 once 2 words are buffered; all 5 words delivered in order, none dropped or duplicated.
- count=0 -> no rom_cen, no m_valid, done pulse, busy=1 for exactly one cycle.
- Second start pulsed while busy -> ignored; burst length unchanged; a start on the done cycle is ignored, and a start one cycle later is accepted.
- reset asserted mid-burst after 2 words -> all outputs go to 0 the next cycle, no done; a subsequent start with count=3 runs cleanly from base.
